// File: rtl/led_clock_controller.sv
// -----------------------------------------------------------------------------
// led_clock_controller
//
// Generates a slow, programmable LED clock from sys_clk. Each output period is
// high_r cycles high followed by (period_r - high_r) cycles low. A new
// configuration can be offered at any time through a valid/ready handshake:
//   - in IDLE it becomes active immediately;
//   - while running it is parked in a one-entry shadow slot and swapped in
//     at the next period boundary, so a period in progress is never altered.
// Configurations that cannot produce a legal waveform are refused with a
// one-cycle cfg_err pulse and leave every stored setting untouched.
//
// Parameters
//   WIDTH       counter and configuration field width
//   DEF_PERIOD  period (sys_clk cycles) loaded by reset
//   DEF_HIGH    high-phase length (sys_clk cycles) loaded by reset
//
// Ports
//   sys_clk     single clock, rising edge
//   reset       synchronous, active-high
//   enable      level request to run the output clock
//   cfg_valid   a new configuration is offered
//   cfg_period  requested period in cycles
//   cfg_high    requested high-phase length in cycles
//   cfg_ready   shadow slot is free (no swap pending)
//   cfg_err     one-cycle pulse after a rejected configuration
//   clk_out     generated LED clock
//   tick        one-cycle pulse in the first cycle of every high phase
//   running     high whenever the controller is not idle
// -----------------------------------------------------------------------------
module led_clock_controller #(
  parameter int unsigned WIDTH      = 28,
  parameter int unsigned DEF_PERIOD = 150_000_000,
  parameter int unsigned DEF_HIGH   = 100_000_000
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_high,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO       = WIDTH'(2);
  localparam logic [WIDTH-1:0] RST_PERIOD = WIDTH'(DEF_PERIOD);
  localparam logic [WIDTH-1:0] RST_HIGH   = WIDTH'(DEF_HIGH);

  state_t           state;
  logic [WIDTH-1:0] counter;

  // Active configuration, used by the period in progress.
  logic [WIDTH-1:0] period_r;
  logic [WIDTH-1:0] high_r;

  // Shadow configuration, waiting for the next period boundary.
  logic [WIDTH-1:0] sh_period;
  logic [WIDTH-1:0] sh_high;
  logic             pending;

  logic handshake;
  logic cfg_bad;
  logic high_end;
  logic low_end;

  // The shadow slot is free exactly when no swap is pending.
  assign cfg_ready = ~pending;
  assign handshake = cfg_valid & ~pending;

  // A legal waveform needs at least one high cycle and at least one low cycle.
  assign cfg_bad = (cfg_period < TWO) || (cfg_high == '0) || (cfg_high >= cfg_period);

  // Last cycle of the high phase and last cycle of the whole period.
  assign high_end = (counter == (high_r - ONE));
  assign low_end  = (counter == (period_r - ONE));

  // ---------------------------------------------------------------------------
  // Sequencer, config intake and all registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: every register here is written with <= so that all of them update
  // together from the values present before the edge; mixing in = would make
  // the result depend on statement order.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      cfg_err  <= 1'b0;
      running  <= 1'b0;
      period_r <= RST_PERIOD;
      high_r   <= RST_HIGH;
      pending  <= 1'b0;
      // NOTE: sh_period/sh_high are deliberately left out of reset; they are
      // only ever read while pending=1, and pending is cleared here.
    end else begin
      // Pulses default low and are raised only on the cycles that need them.
      tick    <= 1'b0;
      cfg_err <= handshake & cfg_bad;

      // Configuration intake. A handshake can only happen with pending=0,
      // so it never collides with the boundary swap below, which needs
      // pending=1.
      if (handshake && !cfg_bad) begin
        if (state == IDLE) begin
          period_r <= cfg_period;
          high_r   <= cfg_high;
        end else begin
          sh_period <= cfg_period;
          sh_high   <= cfg_high;
          pending   <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state   <= HIGH;
            counter <= '0;
            clk_out <= 1'b1;
            tick    <= 1'b1;
            running <= 1'b1;
          end
        end

        HIGH: begin
          counter <= counter + ONE;
          if (high_end) begin
            state   <= LOW;
            clk_out <= 1'b0;
          end
        end

        LOW: begin
          if (low_end) begin
            // Period boundary: the only place the active config may change
            // and the only place enable is honoured once running.
            counter <= '0;
            if (pending) begin
              period_r <= sh_period;
              high_r   <= sh_high;
              pending  <= 1'b0;
            end
            if (enable) begin
              state   <= HIGH;
              clk_out <= 1'b1;
              tick    <= 1'b1;
            end else begin
              state   <= IDLE;
              clk_out <= 1'b0;
              running <= 1'b0;
            end
          end else begin
            counter <= counter + ONE;
          end
        end

        default: begin
          // Unreachable encoding: fall back to a clean idle.
          state   <= IDLE;
          counter <= '0;
          clk_out <= 1'b0;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_clock_controller.sv
// -----------------------------------------------------------------------------
// tb_led_clock_controller
//
// Directed bench for led_clock_controller at WIDTH=8 with scaled-down reset
// defaults (12-cycle period, 7 high) so the default waveform fits a short run.
// Each cycle the five outputs are compared as one vector:
//   {clk_out, tick, running, cfg_ready, cfg_err}
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_led_clock_controller;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned DEF_PERIOD = 12;
  localparam int unsigned DEF_HIGH   = 7;

  logic             sys_clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_period;
  logic [WIDTH-1:0] cfg_high;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             tick;
  logic             running;

  logic [4:0] obs;
  logic [4:0] exp;

  int tests_run = 0;
  int failures  = 0;

  assign obs = {clk_out, tick, running, cfg_ready, cfg_err};

  led_clock_controller #(
    .WIDTH      (WIDTH),
    .DEF_PERIOD (DEF_PERIOD),
    .DEF_HIGH   (DEF_HIGH)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .tick       (tick),
    .running    (running)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Reset wins over enable and a valid config offered in the same cycles.
  task automatic test_reset();
    reset      = 1'b1;
    enable     = 1'b1;
    cfg_valid  = 1'b1;
    cfg_period = 8'd5;
    cfg_high   = 8'd2;
    step();
    step();
    exp = 5'b00010;
    tests_run++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_hold: got %b, expected %b", obs, exp);
    end
    reset     = 1'b0;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    step();
    exp = 5'b00010;
    tests_run++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL post_reset_idle: got %b, expected %b", obs, exp);
    end
  endtask

  // Reset defaults: 7 high, 5 low. Enable drops in the first high cycle and
  // the period still completes before returning to idle.
  task automatic test_defaults();
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      exp = {(k < 7), (k == 0), 3'b110};
      tests_run++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL defaults[%0d]: got %b, expected %b", k, obs, exp);
      end
      enable = 1'b0;
    end
    step();
    exp = 5'b00010;
    tests_run++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL defaults_idle: got %b, expected %b", obs, exp);
    end
  endtask

  // Load 5/2 in idle, then run three periods of 1,1,0,0,0.
  task automatic test_run_config();
    cfg_valid  = 1'b1;
    cfg_period = 8'd5;
    cfg_high   = 8'd2;
    step();
    exp = 5'b00010;
    tests_run++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL idle_load: got %b, expected %b", obs, exp);
    end
    cfg_valid = 1'b0;
    enable    = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      exp = {((k % 5) < 2), ((k % 5) == 0), 3'b110};
      tests_run++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL run_cfg[%0d]: got %b, expected %b", k, obs, exp);
      end
    end
  endtask

  // Offer 4/1 in the second high cycle of a 5/2 period: the period finishes
  // unchanged with cfg_ready low, then 1,0,0,0 periods follow.
  task automatic test_config_swap();
    cfg_period = 8'd4;
    cfg_high   = 8'd1;
    for (int k = 15; k < 20; k++) begin
      cfg_valid = (k == 17);
      step();
      exp = {((k % 5) < 2), ((k % 5) == 0), 1'b1, (k < 17), 1'b0};
      tests_run++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL swap_old[%0d]: got %b, expected %b", k, obs, exp);
      end
    end
    cfg_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      step();
      exp = {((j % 4) == 0), ((j % 4) == 0), 3'b110};
      tests_run++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL swap_new[%0d]: got %b, expected %b", j, obs, exp);
      end
    end
  endtask

  // 3/3 and 6/0 are refused with one-cycle error pulses; 4/1 keeps running.
  task automatic test_rejects();
    for (int j = 8; j < 16; j++) begin
      cfg_valid  = (j == 8) || (j == 10);
      cfg_period = (j == 8) ? 8'd3 : 8'd6;
      cfg_high   = (j == 8) ? 8'd3 : 8'd0;
      step();
      exp = {((j % 4) == 0), ((j % 4) == 0), 1'b1, 1'b1, ((j == 8) || (j == 10))};
      tests_run++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL reject[%0d]: got %b, expected %b", j, obs, exp);
      end
    end
    cfg_valid = 1'b0;
  endtask

  // A 5/2 config offered on the boundary cycle goes to the shadow: the next
  // period is still 4/1, and 5/2 starts at the boundary after it.
  task automatic test_boundary_cfg();
    cfg_period = 8'd5;
    cfg_high   = 8'd2;
    for (int j = 16; j < 20; j++) begin
      cfg_valid = (j == 16);
      step();
      exp = {(j == 16), (j == 16), 1'b1, 1'b0, 1'b0};
      tests_run++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL boundary_cfg[%0d]: got %b, expected %b", j, obs, exp);
      end
    end
    cfg_valid = 1'b0;
  endtask

  // 5/2 period with enable dropped in the second high cycle: 1,1,0,0,0 then idle.
  task automatic test_enable_drop();
    for (int m = 0; m < 5; m++) begin
      step();
      exp = {(m < 2), (m == 0), 3'b110};
      tests_run++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL enable_drop[%0d]: got %b, expected %b", m, obs, exp);
      end
      if (m == 1) enable = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      step();
      exp = 5'b00010;
      tests_run++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL drop_idle[%0d]: got %b, expected %b", i, obs, exp);
      end
    end
  endtask

  // Reset in LOW with a 4/1 swap pending: idle, ready, and two full periods
  // of the 12/7 defaults afterwards.
  task automatic test_reset_mid_run();
    enable = 1'b1;
    step();
    exp = 5'b11110;
    tests_run++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL pre_reset_h0: got %b, expected %b", obs, exp);
    end
    cfg_valid  = 1'b1;
    cfg_period = 8'd4;
    cfg_high   = 8'd1;
    step();
    cfg_valid = 1'b0;
    step();
    exp = 5'b00100;
    tests_run++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL pre_reset_pending: got %b, expected %b", obs, exp);
    end
    reset = 1'b1;
    step();
    exp = 5'b00010;
    tests_run++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_mid_run: got %b, expected %b", obs, exp);
    end
    reset = 1'b0;
    for (int k = 0; k < 24; k++) begin
      step();
      exp = {((k % 12) < 7), ((k % 12) == 0), 3'b110};
      tests_run++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL restored_defaults[%0d]: got %b, expected %b", k, obs, exp);
      end
      if (k == 13) enable = 1'b0;
    end
    step();
    exp = 5'b00010;
    tests_run++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL final_idle: got %b, expected %b", obs, exp);
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_run_config();
    test_config_swap();
    test_rejects();
    test_boundary_cfg();
    test_enable_drop();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/led_clock_controller.md
LED_CLOCK_CONTROLLER -- requirements
Module: led_clock_controller

Interface
REQ-001 The block SHALL have parameter WIDTH, default 28, giving the counter and config field width.
REQ-002 The block SHALL have parameter DEF_PERIOD, default 150_000_000, giving the reset period in sys_clk cycles.
REQ-003 The block SHALL have parameter DEF_HIGH, default 100_000_000, giving the reset high-phase length in sys_clk cycles.
REQ-004 Port sys_clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port reset, input, 1 bit: reset SHALL be synchronous and active-high.
REQ-006 Port enable, input, 1 bit: level request to run the output clock.
REQ-007 Port cfg_valid, input, 1 bit: a new configuration is offered.
REQ-008 Port cfg_period, input, WIDTH bits: requested period in cycles.
REQ-009 Port cfg_high, input, WIDTH bits: requested high-phase length in cycles.
REQ-010 Port cfg_ready, output, 1 bit: the shadow config slot is free.
REQ-011 Port cfg_err, output, 1 bit: one-cycle pulse marking a rejected configuration.
REQ-012 Port clk_out, output, 1 bit: the generated LED clock.
REQ-013 Port tick, output, 1 bit: one-cycle pulse in the first cycle of every high phase.
REQ-014 Port running, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states (IDLE, HIGH, LOW), and all outputs SHALL be registered.
REQ-016 The active config (period_r, high_r), the shadow config (sh_period, sh_high) and a pending flag SHALL be held internally; cfg_ready SHALL equal the inverse of pending.
REQ-017 A handshake SHALL occur on any cycle with cfg_valid=1 and cfg_ready=1.
REQ-018 A handshake with cfg_period<2, cfg_high==0 or cfg_high>=cfg_period SHALL be rejected: the config is not stored, cfg_err=1 on the next cycle, and pending is unchanged.
REQ-019 A valid handshake in IDLE SHALL load the active config directly, leaving pending=0.
REQ-020 A valid handshake in HIGH or LOW SHALL load the shadow and set pending=1.
REQ-021 In IDLE with enable=1, the next cycle SHALL be HIGH with counter=0, clk_out=1 and tick=1.
REQ-022 In HIGH, counter SHALL increment each cycle; when counter==high_r-1 the next cycle SHALL be LOW, clk_out=0, counter=high_r.
REQ-023 In LOW, when counter==period_r-1 (the boundary):
  - counter SHALL return to 0;
  - if pending=1, period_r/high_r SHALL take the shadow values and pending SHALL clear;
  - if enable=1, the next cycle SHALL be HIGH with clk_out=1 and tick=1;
  - if enable=0, the next cycle SHALL be IDLE with clk_out=0.
REQ-024 clk_out SHALL therefore be high for exactly high_r cycles and low for exactly period_r-high_r cycles per period.
REQ-025 Deasserting enable mid-period SHALL NOT truncate the period; the current period completes first.
REQ-026 A handshake coinciding with the boundary cycle while pending=0 SHALL go to the shadow and take effect at the following boundary.
REQ-027 A new config SHALL never alter the period in progress.
REQ-028 Counter arithmetic SHALL be unsigned WIDTH-bit, and the counter SHALL never exceed period_r-1.
REQ-029 tick SHALL be 0 on every cycle other than the HIGH entry cycle.
REQ-030 cfg_err SHALL be 0 on every cycle other than the one following a rejection.

Reset
REQ-031 While reset=1 the block SHALL force, on the next edge:
  - state=IDLE, counter=0;
  - clk_out=0, tick=0, cfg_err=0, running=0;
  - period_r=DEF_PERIOD, high_r=DEF_HIGH;
  - pending=0, so cfg_ready=1.
REQ-032 Reset SHALL take priority over enable and cfg_valid in the same cycle.
REQ-033 Reset asserted mid-period SHALL discard both the period in progress and any pending shadow.

Verification
REQ-034 Run config: with WIDTH=8, configure period=5/high=2 in IDLE, then enable=1 -> clk_out pattern 1,1,0,0,0 repeating, tick every 5 cycles, running=1.
REQ-035 Config swap: with period=5/high=2 running, send period=4/high=1 mid-period -> cfg_ready drops, the current period completes unchanged, the next period is 1,0,0,0, and cfg_ready returns to 1 at the boundary.
REQ-036 Rejections: cfg_period=3 with cfg_high=3, and separately cfg_high=0 -> cfg_err pulses one cycle each, and the active config is unchanged.
REQ-037 Enable drop: enable drops in the second high cycle -> the period finishes (0,0,0), then IDLE with clk_out=0 and running=0.
REQ-038 Reset mid-run: reset asserted during LOW with pending=1 -> next cycle IDLE, clk_out=0, cfg_ready=1, and defaults DEF_PERIOD/DEF_HIGH restored.
REQ-039 Defaults: after reset, enable=1 with no config at default parameters -> clk_out high for 100_000_000 cycles and low for 50_000_000 cycles.
